muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the multicycle core's execute stage. It sits beside the single-cycle ALU on the same operand buses (a, b) and drives the second input of the execute-result mux. The control FSM stalls on `busy` and selects this block's `out` for writeback when `done` pulses. Each operation completes in a fixed 33 cycles using one 32-step shift-add or restoring-divide datapath.

---
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | muldiv_unit: iterative RV32M multiply/divide, fixed 33-cycle latency   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [4:0]      cnt;
  logic [2:0]      op_q;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] hi, lo, dvs;
  logic [XLEN-1:0] hi_nx, lo_nx;
  logic            sp_en;
  logic [XLEN-1:0] sp_val;

  logic            accept, last;
  logic            a_signed, b_signed;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, ovf;
  logic [XLEN:0]   sum, trial;
  logic [63:0]     prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, result;

  assign accept   = start && (state != S_CALC);
  assign last     = (state == S_CALC) && (cnt == 5'd31);
  assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign mag_a    = (a_signed && a[XLEN-1]) ? -a : a;
  assign mag_b    = (b_signed && b[XLEN-1]) ? -b : b;
  assign b_zero   = (b == '0);
  assign ovf      = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = accept ? S_CALC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // hi/lo hold {acc_hi, multiplier/acc_lo} for multiply and {remainder, quotient} for divide.
  always_comb begin
    sum   = {1'b0, hi} + {1'b0, (lo[0] ? dvs : '0)};
    trial = {hi, lo[XLEN-1]} - {1'b0, dvs};
    if (op_q[2]) begin
      if (!trial[XLEN]) begin
        hi_nx = trial[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = {hi[XLEN-2:0], lo[XLEN-1]};
        lo_nx = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    quo_s  = (neg_a ^ neg_b) ? -lo_nx : lo_nx;
    rem_s  = neg_a ? -hi_nx : hi_nx;
    if (op_q[2])             result = op_q[1] ? rem_s : quo_s;
    else if (op_q == 3'd0)   result = prod_s[31:0];
    else                     result = prod_s[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      sp_en  <= 1'b0;
      sp_val <= '0;
      out    <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        op_q   <= op;
        neg_a  <= a_signed && a[XLEN-1];
        neg_b  <= b_signed && b[XLEN-1];
        hi     <= '0;
        lo     <= op[2] ? mag_a : mag_b;
        dvs    <= op[2] ? mag_b : mag_a;
        sp_en  <= op[2] && (b_zero || ovf);
        if (b_zero) sp_val <= op[1] ? a : 32'hFFFF_FFFF;
        else        sp_val <= op[1] ? 32'h0 : 32'h8000_0000;
      end else if (state == S_CALC) begin
        cnt <= cnt + 5'd1;
        hi  <= hi_nx;
        lo  <= lo_nx;
      end
      if (last) out <= sp_en ? sp_val : result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_muldiv_unit: directed scoreboard bench for muldiv_unit              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] out;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_out = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: busy window follows the oldest outstanding op; done pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_busy;
      exp_busy = (sb.size() > 0) && (cyc > sb[0].cyc - 33) && (cyc < sb[0].cyc);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("done_busy_excl", {31'b0, done & busy}, 32'b0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("stray_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, "_out"}, out, e.val);
          chk({e.nm, "_cycle"}, cyc, e.cyc);
        end
      end else begin
        if (sb.size() > 0 && cyc >= sb[0].cyc) begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, "_missing_done"}, 32'd0, 32'd1);
        end
        if (out !== last_out) chk("out_changed_without_done", out, last_out);
      end
    end
    last_out = out;
  end

  // Called in the cycle the op is launched; returns one cycle later.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input string nm);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back('{val: e, cyc: cyc + 33, nm: nm});
    @(posedge clk); #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e, input string nm);
    issue(o, x, y, e, nm);
    repeat (33) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_out", out, 32'd0);
    rst_n = 1'b1;

    // MUL 7 * -3, with out held at cycle 40
    begin
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
      repeat (39) @(posedge clk);
      #1;
      chk("mul_hold_c40", out, 32'hFFFF_FFEB);
    end

    run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");
    run(3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulh_m1_2");

    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    run(3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, "divu_m7_2");
    run(3'd7, 32'hFFFF_FFF9, 32'd2, 32'd1,         "remu_m7_2");

    run(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    run(3'd6, 32'd5, 32'd0, 32'd5,         "rem_by0");
    run(3'd7, 32'd5, 32'd0, 32'd5,         "remu_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");

    // start pulsed at cycle 10 of an operation is ignored
    begin
      issue(3'd5, 32'd100, 32'd7, 32'd14, "divu_ign");
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1;
      op    = 3'd0;
      a     = 32'd3;
      b     = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (23) @(posedge clk);
      #1;
    end

    // back-to-back: start in the DONE cycle
    begin
      issue(3'd0, 32'd6, 32'd9, 32'd54, "b2b_first");
      repeat (32) @(posedge clk);
      #1;
      issue(3'd7, 32'd100, 32'd7, 32'd2, "b2b_second");
      repeat (33) @(posedge clk);
      #1;
    end

    // async reset at cycle 15 of a DIV, then a fresh MUL
    begin
      issue(3'd4, 32'd1000, 32'd3, 32'd333, "div_aborted");
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_out", out, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      run(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_rst");
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
